// File: rtl/uart_frame_tx.sv
// Packet framer: buffers payload bytes in a FIFO and, on request, emits
// HEADER, LEN, payload, CHK through a strobe/busy byte-transmit handshake.
module uart_frame_tx #(
    parameter int          DEPTH   = 16,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          BUSY_TO = 4
) (
    input  logic                     input_clk,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     send,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    // LEN travels as one byte, so a full 256-entry FIFO cannot be framed.
    if ((DEPTH < 2) || (DEPTH > 128) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_frame_tx: DEPTH must be a power of 2 in 2..128");
    end
    if (BUSY_TO < 1) begin : g_bad_busy_to
        $error("uart_frame_tx: BUSY_TO must be at least 1");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_LEN, ST_PAY, ST_CHK} state_t;
    typedef enum logic [1:0] {BY_ISSUE, BY_WAIT_HI, BY_WAIT_LO} byte_t;

    state_t          state, state_d;
    byte_t           sub, sub_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, len_q, pay_cnt;
    logic [7:0]      csum, byte_val;
    logic [TW-1:0]   to_cnt;
    logic            accept, issue, byte_done, frame_end, push, pop;

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE);
    assign push       = wr_en && !fifo_full;
    assign pop        = issue && (state == ST_PAY);
    assign accept     = (state == ST_IDLE) && send;
    assign frame_end  = (state == ST_CHK) && byte_done;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sub   <= BY_ISSUE;
        end else begin
            state <= state_d;
            sub   <= sub_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state;
        sub_d     = sub;
        issue     = 1'b0;
        byte_done = 1'b0;
        byte_val  = 8'h00;
        case (state)
            ST_HDR:  byte_val = HEADER;
            ST_LEN:  byte_val = 8'(len_q);
            ST_PAY:  byte_val = mem[rd_ptr];
            ST_CHK:  byte_val = ~csum + 8'd1;
            default: byte_val = 8'h00;
        endcase

        if (state == ST_IDLE) begin
            sub_d = BY_ISSUE;
            if (send) state_d = ST_HDR;
        end else begin
            case (sub)
                BY_ISSUE: begin
                    if (!tx_busy) begin
                        issue = 1'b1;
                        sub_d = BY_WAIT_HI;
                    end
                end
                BY_WAIT_HI: begin
                    if (tx_busy || (to_cnt == TO_LAST)) sub_d = BY_WAIT_LO;
                end
                BY_WAIT_LO: begin
                    if (!tx_busy) begin
                        byte_done = 1'b1;
                        sub_d     = BY_ISSUE;
                        case (state)
                            ST_HDR:  state_d = ST_LEN;
                            ST_LEN:  state_d = (len_q == '0) ? ST_CHK : ST_PAY;
                            ST_PAY:  state_d = (pay_cnt == '0) ? ST_CHK : ST_PAY;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
                default: sub_d = BY_ISSUE;
            endcase
        end
    end

    // NOTE: payload storage is left unreset; the pointers and count define validity.
    always_ff @(posedge input_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            len_q    <= '0;
            pay_cnt  <= '0;
            csum     <= 8'h00;
            to_cnt   <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= issue;
            done     <= frame_end;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (accept)        overflow <= 1'b0;

            // Checksum covers LEN and payload only; header is excluded.
            if (accept) begin
                len_q   <= count;
                pay_cnt <= count;
                csum    <= 8'h00;
            end else if (issue && ((state == ST_LEN) || (state == ST_PAY))) begin
                csum <= csum + byte_val;
            end
            if (pop) pay_cnt <= pay_cnt - CW'(1);

            if (issue) begin
                tx_data <= byte_val;
                to_cnt  <= '0;
            end else if (sub == BY_WAIT_HI) begin
                to_cnt  <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: a reference framer fills an expected-byte
// queue at each send; a monitor pops and compares it on every tx_start strobe.
module tb_uart_frame_tx;

    localparam int          DEPTH   = 16;
    localparam logic [7:0]  HEADER  = 8'hA5;
    localparam int          BUSY_TO = 4;
    localparam int          BUSY_LEN = 10;

    logic        input_clk;
    logic        reset;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        overflow;
    logic        send;
    logic        busy;
    logic        done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    uart_frame_tx #(.DEPTH(DEPTH), .HEADER(HEADER), .BUSY_TO(BUSY_TO)) dut (
        .input_clk  (input_clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_done = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit gap_armed = 0;
    bit check_gaps = 0;
    bit busy_model_en = 1;
    logic [7:0] exp_q[$];
    logic [7:0] m_fifo[$];
    bit m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    initial begin
        input_clk = 1'b0;
        forever #5 input_clk = ~input_clk;
    end

    initial forever begin
        @(posedge input_clk);
        cyc++;
    end

    // Strobe monitor plus a transmitter model that holds tx_busy high after each strobe.
    initial begin
        int busy_left;
        logic [7:0] want;
        busy_left = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge input_clk);
            if (tx_start) begin
                n_strobe++;
                check("no_start_while_busy", 32'(tx_busy), 0);
                check("strobe_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(want));
                end
                if (check_gaps && gap_armed)
                    check("timeout_gap", 32'((cyc - last_cyc >= BUSY_TO) && (cyc - last_cyc <= BUSY_TO + 3)), 1);
                gap_armed = 1;
                last_cyc = cyc;
            end
            if (done) n_done++;
            if (tx_start && busy_model_en) busy_left = BUSY_LEN;
            else if (busy_left != 0)       busy_left--;
            tx_busy = (busy_left != 0);
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge input_clk);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge input_clk);
        wr_en   = 1'b0;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
        else                       m_ovf = 1;
    endtask

    // Reference framer: snapshot the modelled FIFO and queue the whole frame.
    task automatic model_frame();
        int len;
        logic [7:0] sum, b;
        len = m_fifo.size();
        exp_q.push_back(HEADER);
        exp_q.push_back(8'(len));
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = m_fifo.pop_front();
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(8'(0) - sum);
        m_ovf = 0;
    endtask

    task automatic pulse_send(input bit expect_accept);
        @(negedge input_clk);
        if (expect_accept) model_frame();
        gap_armed = 0;
        send = 1'b1;
        @(negedge input_clk);
        send = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(negedge input_clk);
        end
        check({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_tx_data"},    32'(tx_data), 0);
        check({tag, "_tx_start"},   32'(tx_start), 0);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_done"},       32'(done), 0);
        check({tag, "_overflow"},   32'(overflow), 0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_fifo_full"},  32'(fifo_full), 0);
    endtask

    initial begin
        int s0;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        send    = 1'b0;
        repeat (2) @(negedge input_clk);
        check_cleared("por");
        reset = 1'b1;

        // Basic three-byte frame with a slow transmitter.
        foreach (m_fifo[i]) m_fifo.delete();
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        check("t1_count_pre", 32'(fifo_count), 3);
        s0 = n_strobe; n_done = 0;
        pulse_send(1);
        wait_frame("t1");
        repeat (3) @(negedge input_clk);
        check("t1_strobes", 32'(n_strobe - s0), 6);
        check("t1_done", 32'(n_done), 1);
        check("t1_count", 32'(fifo_count), 0);

        // Empty frame.
        s0 = n_strobe; n_done = 0;
        pulse_send(1);
        wait_frame("t2");
        repeat (3) @(negedge input_clk);
        check("t2_strobes", 32'(n_strobe - s0), 3);
        check("t2_done", 32'(n_done), 1);
        check("t2_count", 32'(fifo_count), 0);

        // Overflow: DEPTH+1 writes, last one dropped.
        for (int i = 0; i <= DEPTH; i++) write_byte(8'(8'h10 + i));
        check("t3_full", 32'(fifo_full), 1);
        check("t3_overflow", 32'(overflow), 32'(m_ovf));
        check("t3_count", 32'(fifo_count), DEPTH);
        s0 = n_strobe;
        pulse_send(1);
        check("t3_overflow_cleared", 32'(overflow), 32'(m_ovf));
        check("t3_busy", 32'(busy), 1);
        wait_frame("t3");
        check("t3_strobes", 32'(n_strobe - s0), DEPTH + 3);
        check("t3_count_after", 32'(fifo_count), 0);

        // Mid-frame write and ignored mid-frame send.
        write_byte(8'hAA); write_byte(8'hBB);
        pulse_send(1);
        repeat (5) @(negedge input_clk);
        write_byte(8'hCC);
        check("t4_busy_mid", 32'(busy), 1);
        pulse_send(0);
        wait_frame("t4a");
        repeat (3) @(negedge input_clk);
        check("t4_count_left", 32'(fifo_count), 1);
        pulse_send(1);
        wait_frame("t4b");
        check("t4_count_after", 32'(fifo_count), 0);

        // Transmitter never raises busy: every byte advances on the timeout.
        busy_model_en = 0;
        write_byte(8'h5A); write_byte(8'hC3); write_byte(8'h7E);
        s0 = n_strobe; n_done = 0;
        check_gaps = 1;
        pulse_send(1);
        wait_frame("t5");
        check_gaps = 0;
        repeat (3) @(negedge input_clk);
        check("t5_strobes", 32'(n_strobe - s0), 6);
        check("t5_done", 32'(n_done), 1);
        busy_model_en = 1;

        // Reset during the payload of a four-byte frame.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        s0 = n_strobe;
        pulse_send(1);
        for (int i = 0; i < 2000 && (n_strobe - s0) < 3; i++) @(negedge input_clk);
        check("t6_reached_pay", 32'((n_strobe - s0) >= 3), 1);
        #1;
        reset = 1'b0;
        #1;
        check_cleared("t6_rst");
        exp_q.delete();
        m_fifo.delete();
        m_ovf = 0;
        @(negedge input_clk);
        reset = 1'b1;
        s0 = n_strobe;
        repeat (40) @(negedge input_clk);
        check("t6_no_strobe", 32'(n_strobe - s0), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_count", 32'(fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
